// File: rtl/sub4_serial_if.sv
// sub4_serial_if: start/busy/done handshake bus; master drives start/a/b/bin, slave returns busy/done/diff/bout
interface sub4_serial_if #(parameter int W = 4);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/sub4_serial.sv
// sub4_serial: bit-serial LSB-first W-bit subtractor diff=a-b-bin; ports clk, rst (async high), bus (slave: start/a/b/bin in, busy/done/diff/bout out)
module sub4_serial #(parameter int W = 4) (
  input logic         clk,
  input logic         rst,
  sub4_serial_if.slave bus
);
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  sa_q, sb_q, res_q, diff_q;
  logic          brw_q, bout_q, busy_q, done_q;
  logic          d_bit, brw_d;
  logic [W-1:0]  res_d;
  assign d_bit = sa_q[0] ^ sb_q[0] ^ brw_q;
  assign brw_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
  assign res_d = {d_bit, res_q[W-1:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          sa_q    <= bus.a;
          sb_q    <= bus.b;
          brw_q   <= bus.bin;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
      end else begin
        sa_q  <= sa_q >> 1;
        sb_q  <= sb_q >> 1;
        brw_q <= brw_d;
        res_q <= res_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          diff_q  <= res_d;
          bout_q  <= brw_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_sub4_serial.sv
// tb_sub4_serial: directed self-checking bench for sub4_serial
module tb_sub4_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  sub4_serial_if #(.W(4)) bus ();
  sub4_serial #(.W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic ibin);
    bus.a = ia;
    bus.b = ib;
    bus.bin = ibin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.done && cyc < 20);
    if (!bus.done) cyc = -1;
  endtask
  task automatic test_reset;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.diff !== 4'h0) begin n_bad++; $display("FAIL reset_diff: got %h expected 0", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout: got %b expected 0", bus.bout); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_basic;
    issue(4'b0101, 4'b0011, 1'b0);
    n_cmp++; if ({bus.busy, bus.done} !== 2'b10) begin n_bad++; $display("FAIL basic_accept: busy,done got %b expected 10", {bus.busy, bus.done}); end
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_cmp++; if ({bus.busy, bus.done} !== 2'b10) begin n_bad++; $display("FAIL basic_run%0d: busy,done got %b expected 10", k, {bus.busy, bus.done}); end
    end
    @(posedge clk);
    #1;
    n_cmp++; if ({bus.busy, bus.done} !== 2'b01) begin n_bad++; $display("FAIL basic_done: busy,done got %b expected 01", {bus.busy, bus.done}); end
    n_cmp++; if (bus.diff !== 4'b0010) begin n_bad++; $display("FAIL basic_diff: got %b expected 0010", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL basic_bout: got %b expected 0", bus.bout); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: done got %b expected 0", bus.done); end
    n_cmp++; if (bus.diff !== 4'b0010) begin n_bad++; $display("FAIL basic_hold: diff got %b expected 0010", bus.diff); end
  endtask
  task automatic test_back_to_back;
    logic [3:0] va[4] = '{4'b0011, 4'b0000, 4'b1111, 4'b1010};
    logic [3:0] vb[4] = '{4'b0101, 4'b0000, 4'b1111, 4'b0101};
    logic       vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ed[4] = '{4'b1110, 4'b1111, 4'b1111, 4'b0101};
    logic       eb[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int cyc;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a = va[i];
      bus.b = vb[i];
      bus.bin = vc[i];
      wait_done(cyc);
      n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 5", i, cyc); end
      n_cmp++; if (bus.diff !== ed[i]) begin n_bad++; $display("FAIL b2b_diff%0d: got %b expected %b", i, bus.diff, ed[i]); end
      n_cmp++; if (bus.bout !== eb[i]) begin n_bad++; $display("FAIL b2b_bout%0d: got %b expected %b", i, bus.bout, eb[i]); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_excl%0d: busy got %b expected 0 while done", i, bus.busy); end
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_isolation;
    int cyc;
    int extra;
    issue(4'b1000, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    bus.a = 4'b0000;
    bus.b = 4'b0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL iso_latency: got %0d cycles expected 2", cyc); end
    n_cmp++; if (bus.diff !== 4'b0111) begin n_bad++; $display("FAIL iso_diff: got %b expected 0111", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL iso_bout: got %b expected 0", bus.bout); end
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL iso_no_second: got %0d active cycles expected 0", extra); end
  endtask
  task automatic test_reset_mid;
    int cyc;
    int seen;
    issue(4'b1111, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.diff !== 4'h0) begin n_bad++; $display("FAIL rstmid_diff: got %b expected 0000", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL rstmid_bout: got %b expected 0", bus.bout); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_discard: got %0d active cycles expected 0", seen); end
    issue(4'b0110, 4'b0010, 1'b0);
    wait_done(cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL rstmid_latency: got %0d cycles expected 4", cyc); end
    n_cmp++; if (bus.diff !== 4'b0100) begin n_bad++; $display("FAIL rstmid_diff2: got %b expected 0100", bus.diff); end
    n_cmp++; if (bus.bout !== 1'b0) begin n_bad++; $display("FAIL rstmid_bout2: got %b expected 0", bus.bout); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_sweep;
    int cyc;
    logic [4:0] full;
    logic       eb;
    bus.start = 1'b1;
    for (int x = 0; x < 512; x++) begin
      bus.a = x[8:5];
      bus.b = x[4:1];
      bus.bin = x[0];
      full = {1'b0, x[8:5]} - {1'b0, x[4:1]} - {4'b0, x[0]};
      eb = (int'(x[8:5]) < int'(x[4:1]) + int'(x[0]));
      wait_done(cyc);
      n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL sweep_spacing a=%h b=%h bin=%b: got %0d expected 5", x[8:5], x[4:1], x[0], cyc); end
      n_cmp++; if (bus.diff !== full[3:0]) begin n_bad++; $display("FAIL sweep_diff a=%h b=%h bin=%b: got %h expected %h", x[8:5], x[4:1], x[0], bus.diff, full[3:0]); end
      n_cmp++; if (bus.bout !== eb) begin n_bad++; $display("FAIL sweep_bout a=%h b=%h bin=%b: got %b expected %b", x[8:5], x[4:1], x[0], bus.bout, eb); end
    end
    bus.start = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_isolation();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
